// File: rtl/vec_ctrl_pkg.sv
// Shared types, Gray state codes and per-step control tables for the
// dot-product control sequencer.
package vec_ctrl_pkg;

  localparam int unsigned NSTEP = 12;

  localparam logic [3:0] S1  = 4'b0000;
  localparam logic [3:0] S2  = 4'b0001;
  localparam logic [3:0] S3  = 4'b0011;
  localparam logic [3:0] S4  = 4'b0010;
  localparam logic [3:0] S5  = 4'b0110;
  localparam logic [3:0] S6  = 4'b0111;
  localparam logic [3:0] S7  = 4'b1111;
  localparam logic [3:0] S8  = 4'b1110;
  localparam logic [3:0] S9  = 4'b1010;
  localparam logic [3:0] S10 = 4'b1011;
  localparam logic [3:0] S11 = 4'b1001;
  localparam logic [3:0] S12 = 4'b1000;

  // Main step index 0..11; activity is tracked by a separate flag.
  typedef logic [3:0] step_t;
  localparam step_t LAST_STEP = 4'd11;

  typedef enum logic [1:0] {
    TAIL_IDLE = 2'd0,
    T12       = 2'd1,
    T13       = 2'd2,
    T14       = 2'd3
  } tail_t;

  typedef logic [9:0] vec_t;

  localparam logic [3:0] STATE_TBL [NSTEP] = '{
    S1, S2, S3, S4, S5, S6, S7, S8, S9, S10, S11, S12
  };

  localparam vec_t LOAD_TBL [NSTEP] = '{
    10'h001, 10'h002, 10'h004, 10'h008, 10'h010, 10'h020,
    10'h040, 10'h080, 10'h100, 10'h200, 10'h100, 10'h200
  };

  localparam vec_t MUL_EN_TBL [NSTEP] = '{
    10'h000, 10'h000, 10'h000, 10'h000, 10'h000, 10'h011,
    10'h022, 10'h044, 10'h088, 10'h000, 10'h000, 10'h000
  };

  localparam vec_t MUL_READ_TBL [NSTEP] = '{
    10'h000, 10'h000, 10'h000, 10'h000, 10'h000, 10'h000,
    10'h001, 10'h002, 10'h004, 10'h008, 10'h000, 10'h000
  };

  localparam vec_t ADD1_EN_TBL [NSTEP] = '{
    10'h000, 10'h000, 10'h000, 10'h000, 10'h000, 10'h000,
    10'h000, 10'h000, 10'h000, 10'h101, 10'h202, 10'h104
  };

  localparam vec_t ADD2_EN_TBL [NSTEP] = '{
    10'h000, 10'h000, 10'h000, 10'h000, 10'h000, 10'h000,
    10'h000, 10'h000, 10'h000, 10'h000, 10'h011, 10'h022
  };

  localparam vec_t ADD1_READ_TBL [NSTEP] = '{
    10'h000, 10'h000, 10'h000, 10'h000, 10'h000, 10'h000,
    10'h000, 10'h000, 10'h000, 10'h000, 10'h001, 10'h002
  };

  localparam vec_t T12_ADD1_EN   = 10'h208;
  localparam vec_t T12_ADD2_EN   = 10'h044;
  localparam vec_t T12_ADD1_READ = 10'h004;
  localparam vec_t T13_ADD2_EN   = 10'h088;
  localparam vec_t T13_ADD1_READ = 10'h008;

endpackage

// File: rtl/vec_ctrl_rom.sv
// Combinational control map: the main-step vector ORed with the
// accumulate-tail vector.
module vec_ctrl_rom
  import vec_ctrl_pkg::*;
(
  input  logic       main_act,
  input  logic [3:0] main_step,
  input  logic [1:0] tail,
  output logic [3:0] state,
  output logic [9:0] load,
  output logic [9:0] mul_en,
  output logic [9:0] add1_en,
  output logic [9:0] add2_en,
  output logic [9:0] mul_read,
  output logic [9:0] add1_read,
  output logic [9:0] add2_read,
  output logic       result_valid
);

  always_comb begin
    state        = S1;
    load         = '0;
    mul_en       = '0;
    add1_en      = '0;
    add2_en      = '0;
    mul_read     = '0;
    add1_read    = '0;
    add2_read    = '0;
    result_valid = 1'b0;

    if (main_act && (main_step <= LAST_STEP)) begin
      state     = STATE_TBL[main_step];
      load      = LOAD_TBL[main_step];
      mul_en    = MUL_EN_TBL[main_step];
      mul_read  = MUL_READ_TBL[main_step];
      add1_en   = ADD1_EN_TBL[main_step];
      add2_en   = ADD2_EN_TBL[main_step];
      add1_read = ADD1_READ_TBL[main_step];
    end

    // Tail vectors never collide with the overlapping early main steps,
    // so a plain OR merges back-to-back frames.
    case (tail_t'(tail))
      T12: begin
        add1_en   = add1_en   | T12_ADD1_EN;
        add2_en   = add2_en   | T12_ADD2_EN;
        add1_read = add1_read | T12_ADD1_READ;
      end
      T13: begin
        add2_en   = add2_en   | T13_ADD2_EN;
        add1_read = add1_read | T13_ADD1_READ;
      end
      T14:     result_valid = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: rtl/vec_ctrl.sv
// Dot-product control sequencer: main step counter, accumulate tail,
// start acceptance and registered control outputs.
module vec_ctrl
  import vec_ctrl_pkg::*;
#(
  parameter int unsigned NREG = 10
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  output logic [3:0]      state,
  output logic [NREG-1:0] load,
  output logic [NREG-1:0] mul_en,
  output logic [NREG-1:0] add1_en,
  output logic [NREG-1:0] add2_en,
  output logic [NREG-1:0] mul_read,
  output logic [NREG-1:0] add1_read,
  output logic [NREG-1:0] add2_read,
  output logic            operand_req,
  output logic            busy,
  output logic            result_valid
);

  if (NREG != 10) begin : g_nreg_check
    $error("vec_ctrl: schedule is defined for NREG = 10 only");
  end

  logic  main_act, main_act_nx;
  step_t main_step, main_step_nx;
  tail_t tail, tail_nx;
  logic  accept;

  logic [3:0] rom_state;
  vec_t       rom_load, rom_mul_en, rom_add1_en, rom_add2_en;
  vec_t       rom_mul_read, rom_add1_read, rom_add2_read;
  logic       rom_result_valid;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      main_act  <= 1'b0;
      main_step <= '0;
      tail      <= TAIL_IDLE;
    end else begin
      main_act  <= main_act_nx;
      main_step <= main_step_nx;
      tail      <= tail_nx;
    end
  end

  always_comb begin
    main_act_nx  = 1'b0;
    main_step_nx = '0;
    tail_nx      = TAIL_IDLE;
    accept       = start && (!main_act || (main_step == LAST_STEP));

    if (accept) begin
      main_act_nx = 1'b1;
    end else if (main_act && (main_step != LAST_STEP)) begin
      main_act_nx  = 1'b1;
      main_step_nx = main_step + 4'd1;
    end

    if (main_act && (main_step == LAST_STEP)) begin
      tail_nx = T12;
    end else begin
      case (tail)
        T12:     tail_nx = T13;
        T13:     tail_nx = T14;
        default: tail_nx = TAIL_IDLE;
      endcase
    end
  end

  // The map is evaluated on next-state values so every output is a flop.
  vec_ctrl_rom u_rom (
    .main_act     (main_act_nx),
    .main_step    (main_step_nx),
    .tail         (tail_nx),
    .state        (rom_state),
    .load         (rom_load),
    .mul_en       (rom_mul_en),
    .add1_en      (rom_add1_en),
    .add2_en      (rom_add2_en),
    .mul_read     (rom_mul_read),
    .add1_read    (rom_add1_read),
    .add2_read    (rom_add2_read),
    .result_valid (rom_result_valid)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state        <= S1;
      load         <= '0;
      mul_en       <= '0;
      add1_en      <= '0;
      add2_en      <= '0;
      mul_read     <= '0;
      add1_read    <= '0;
      add2_read    <= '0;
      operand_req  <= 1'b0;
      busy         <= 1'b0;
      result_valid <= 1'b0;
    end else begin
      state        <= rom_state;
      load         <= rom_load;
      mul_en       <= rom_mul_en;
      add1_en      <= rom_add1_en;
      add2_en      <= rom_add2_en;
      mul_read     <= rom_mul_read;
      add1_read    <= rom_add1_read;
      add2_read    <= rom_add2_read;
      operand_req  <= main_act_nx;
      busy         <= main_act_nx || (tail_nx != TAIL_IDLE);
      result_valid <= rom_result_valid;
    end
  end

endmodule
